player_motion_ctrl: RTL and testbench

//  Drives player_x/player_y for one player_renderer instance (one instance per player).

---
 rtl/player_motion_ctrl_pkg.sv | 25 ++
 rtl/player_motion_ctrl_if.sv | 26 ++
 rtl/player_motion_ctrl_tile_coord_lut.sv | 39 +++
 rtl/player_motion_ctrl.sv | 118 +++++++++++
 tb/tb_player_motion_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/player_motion_ctrl_pkg.sv
// Board geometry, tile index type and motion FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package player_motion_ctrl_pkg;
    localparam int NUM_TILES    = 20;
    localparam int TILE_SIZE    = 32;
    localparam int BOARD_X0_DEF = 160;
    localparam int BOARD_Y0_DEF = 80;
    localparam int SIDE_LEN     = NUM_TILES / 4;
    localparam int TILE_W       = $clog2(NUM_TILES);

    typedef logic [TILE_W-1:0] tile_idx_t;
    typedef logic [9:0]        coord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOP,
        ST_LAND,
        ST_DONE
    } motion_state_t;

    function automatic tile_idx_t next_tile(input tile_idx_t t);
        return (t == tile_idx_t'(NUM_TILES - 1)) ? '0 : t + 1'b1;
    endfunction
endpackage

// File: rtl/player_motion_ctrl_if.sv
// Move request and sprite position bundle between game logic and the motion controller.
// Latency: n/a (wires only).
// Backpressure: none; requests arriving while busy are dropped by the controller.
interface player_motion_ctrl_if;
    import player_motion_ctrl_pkg::*;

    logic      frame_tick;
    logic      move_start;
    logic [2:0] move_steps;
    coord_t    player_x;
    coord_t    player_y;
    tile_idx_t tile_idx;
    logic      busy;
    logic      pass_start;
    logic      move_done;

    modport master (
        output frame_tick, move_start, move_steps,
        input  player_x, player_y, tile_idx, busy, pass_start, move_done
    );

    modport slave (
        input  frame_tick, move_start, move_steps,
        output player_x, player_y, tile_idx, busy, pass_start, move_done
    );
endinterface

// File: rtl/player_motion_ctrl_tile_coord_lut.sv
// Maps a perimeter tile index to the sprite's top-left pixel on that tile.
// Latency: combinational.
// Backpressure: none.
module tile_coord_lut
    import player_motion_ctrl_pkg::*;
#(
    parameter int BOARD_X0   = BOARD_X0_DEF,
    parameter int BOARD_Y0   = BOARD_Y0_DEF,
    parameter int SLOT_X_OFF = 0,
    parameter int SLOT_Y_OFF = 8
) (
    input  tile_idx_t tile,
    output coord_t    px,
    output coord_t    py
);
    int k;
    int col;
    int row;

    // Top edge left->right, right edge down, bottom edge right->left, left edge up.
    always_comb begin
        k   = int'(tile);
        col = 0;
        row = 0;
        if (k <= SIDE_LEN) begin
            col = k;
        end else if (k <= 2 * SIDE_LEN) begin
            col = SIDE_LEN;
            row = k - SIDE_LEN;
        end else if (k <= 3 * SIDE_LEN) begin
            col = 3 * SIDE_LEN - k;
            row = SIDE_LEN;
        end else begin
            row = 4 * SIDE_LEN - k;
        end
        px = coord_t'(BOARD_X0 + col * TILE_SIZE + SLOT_X_OFF);
        py = coord_t'(BOARD_Y0 + row * TILE_SIZE + SLOT_Y_OFF);
    end
endmodule

// File: rtl/player_motion_ctrl.sv
// Hops a player token tile by tile around the board perimeter, interpolating each hop with an arc.
// Latency: position updates on the cycle after each frame_tick; an n-step move takes n*FRAMES_PER_HOP ticks.
// Backpressure: move_start is only accepted when idle; requests while busy are dropped, not queued.
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
#(
    parameter int BOARD_X0       = BOARD_X0_DEF,
    parameter int BOARD_Y0       = BOARD_Y0_DEF,
    parameter int SLOT_X_OFF     = 0,
    parameter int SLOT_Y_OFF     = 8,
    parameter int FRAMES_PER_HOP = 8,
    parameter int HOP_HEIGHT     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    player_motion_ctrl_if.slave  mif
);
    localparam int LOG2F = $clog2(FRAMES_PER_HOP);
    localparam int FW    = LOG2F + 1;
    localparam logic [FW-1:0] F_LAST = FRAMES_PER_HOP[FW-1:0];
    localparam logic [FW-1:0] F_HALF = F_LAST >> 1;

    motion_state_t   state_q, state_d;
    logic [FW-1:0]   f_q, f_nxt, arc_f;
    logic [2:0]      remaining_q;
    tile_idx_t       src_q, dst_q, tile_q;
    coord_t          x_q, y_q, src_x, src_y, dst_x, dst_y;
    logic signed [15:0] dx, dy, ix, iy, arc, f_s;
    logic            hop_tick, pass_start, move_done;

    tile_coord_lut #(.BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0),
                     .SLOT_X_OFF(SLOT_X_OFF), .SLOT_Y_OFF(SLOT_Y_OFF))
        u_src_lut (.tile(src_q), .px(src_x), .py(src_y));

    tile_coord_lut #(.BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0),
                     .SLOT_X_OFF(SLOT_X_OFF), .SLOT_Y_OFF(SLOT_Y_OFF))
        u_dst_lut (.tile(dst_q), .px(dst_x), .py(dst_y));

    assign f_nxt    = f_q + 1'b1;
    assign hop_tick = (state_q == ST_HOP) && mif.frame_tick;

    // Position for the frame about to be shown; arc is zero at both hop ends.
    always_comb begin
        f_s   = $signed({{(16-FW){1'b0}}, f_nxt});
        dx    = $signed({6'd0, dst_x}) - $signed({6'd0, src_x});
        dy    = $signed({6'd0, dst_y}) - $signed({6'd0, src_y});
        arc_f = (f_nxt <= F_HALF) ? f_nxt : F_LAST - f_nxt;
        arc   = 16'(HOP_HEIGHT * int'(arc_f) / (FRAMES_PER_HOP / 2));
        ix    = $signed({6'd0, src_x}) + ((dx * f_s) >>> LOG2F);
        iy    = $signed({6'd0, src_y}) + ((dy * f_s) >>> LOG2F) - arc;
    end

    always_comb begin
        state_d    = state_q;
        pass_start = 1'b0;
        move_done  = 1'b0;
        case (state_q)
            ST_IDLE: if (mif.move_start) state_d = (mif.move_steps != 3'd0) ? ST_HOP : ST_DONE;
            ST_HOP:  if (hop_tick && (f_nxt == F_LAST)) state_d = ST_LAND;
            ST_LAND: begin
                pass_start = (dst_q == '0);
                state_d    = (remaining_q == 3'd1) ? ST_DONE : ST_HOP;
            end
            ST_DONE: begin
                move_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            f_q         <= '0;
            remaining_q <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            tile_q      <= '0;
            x_q         <= coord_t'(BOARD_X0 + SLOT_X_OFF);
            y_q         <= coord_t'(BOARD_Y0 + SLOT_Y_OFF);
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (mif.move_start && (mif.move_steps != 3'd0)) begin
                        remaining_q <= mif.move_steps;
                        src_q       <= tile_q;
                        dst_q       <= next_tile(tile_q);
                        f_q         <= '0;
                    end
                end
                ST_HOP: begin
                    if (hop_tick) begin
                        f_q <= f_nxt;
                        x_q <= coord_t'(ix);
                        y_q <= coord_t'(iy);
                    end
                end
                ST_LAND: begin
                    tile_q      <= dst_q;
                    remaining_q <= remaining_q - 3'd1;
                    src_q       <= dst_q;
                    dst_q       <= next_tile(dst_q);
                    f_q         <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mif.player_x   = x_q;
    assign mif.player_y   = y_q;
    assign mif.tile_idx   = tile_q;
    assign mif.busy       = (state_q != ST_IDLE);
    assign mif.pass_start = pass_start;
    assign mif.move_done  = move_done;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed and randomized moves around the board, checked against a perimeter-walk model.
module tb_player_motion_ctrl;
    import player_motion_ctrl_pkg::*;

    localparam int NT = 20;
    localparam int S  = NT / 4;
    localparam int F  = 8;
    localparam int HH = 8;
    localparam int TS = 32;
    localparam int X0 = 160;
    localparam int Y0 = 80;
    localparam int SX = 0;
    localparam int SY = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    player_motion_ctrl_if mif();

    player_motion_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    int mt = 0;
    int col_tab[NT];
    int row_tab[NT];

    always @(negedge clk) begin
        if (mif.pass_start === 1'b1) pass_cnt++;
        if (mif.move_done === 1'b1) done_cnt++;
    end

    function automatic int cx(input int t);
        return X0 + col_tab[t] * TS + SX;
    endfunction

    function automatic int cy(input int t);
        return Y0 + row_tab[t] * TS + SY;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 32'(mif.player_x), ex);
        check({tag, "_y"}, 32'(mif.player_y), ey);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input int n, input int gap_lo, input int gap_hi,
                           input bit land_tick, input bit busy_req, input bit start_tick);
        int p0, d0, src, dst, exp_pass, ex, ey, a;
        p0 = pass_cnt;
        d0 = done_cnt;
        exp_pass = 0;
        mif.move_start = 1'b1;
        mif.move_steps = 3'(n);
        mif.frame_tick = start_tick;
        step();
        mif.move_start = 1'b0;
        mif.frame_tick = 1'b0;
        check("busy_after_accept", 32'(mif.busy), 1);
        check_pos("accept", cx(mt), cy(mt));
        for (int h = 0; h < n; h++) begin
            src = mt;
            dst = (mt + 1) % NT;
            for (int f = 1; f <= F; f++) begin
                mif.frame_tick = 1'b1;
                step();
                mif.frame_tick = 1'b0;
                a  = HH * ((f < F - f) ? f : F - f) / (F / 2);
                ex = cx(src) + ((cx(dst) - cx(src)) * f) / F;
                ey = cy(src) + ((cy(dst) - cy(src)) * f) / F - a;
                check_pos("hop", ex, ey);
                if (f < F) begin
                    if (busy_req && h == 0 && f == 1) begin
                        mif.move_start = 1'b1;
                        mif.move_steps = 3'd5;
                        step();
                        mif.move_start = 1'b0;
                    end
                    repeat ($urandom_range(gap_hi, gap_lo)) step();
                    check_pos("hold", ex, ey);
                end
            end
            if (land_tick) mif.frame_tick = 1'b1;
            step();
            mif.frame_tick = 1'b0;
            mt = dst;
            if (dst == 0) exp_pass++;
            check("tile_land", 32'(mif.tile_idx), mt);
            check_pos("land", cx(mt), cy(mt));
            step();
        end
        for (int w = 0; w < 4 && mif.busy; w++) step();
        check("busy_clear", 32'(mif.busy), 0);
        check("move_done_pulses", done_cnt - d0, 1);
        check("pass_pulses", pass_cnt - p0, exp_pass);
        check("final_tile", 32'(mif.tile_idx), mt);
        check_pos("final", cx(mt), cy(mt));
    endtask

    initial begin
        int c, r;
        c = 0;
        r = 0;
        for (int i = 0; i < NT; i++) begin
            col_tab[i] = c;
            row_tab[i] = r;
            if (i < S) c++;
            else if (i < 2 * S) r++;
            else if (i < 3 * S) c--;
            else r--;
        end

        mif.frame_tick = 1'b0;
        mif.move_start = 1'b0;
        mif.move_steps = 3'd0;
        repeat (3) step();
        check("rst_tile", 32'(mif.tile_idx), 0);
        check_pos("rst", 160, 88);
        check("rst_busy", 32'(mif.busy), 0);
        check("rst_pass", 32'(mif.pass_start), 0);
        check("rst_done", 32'(mif.move_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_move(1, 0, 2, 1'b0, 1'b0, 1'b0);   // 0 -> 1
        check_pos("t2_end", 192, 88);
        do_move(4, 0, 1, 1'b1, 1'b0, 1'b0);   // 1 -> 5
        check_pos("t3_start", 320, 88);
        do_move(1, 0, 2, 1'b0, 1'b0, 1'b1);   // corner 5 -> 6
        check_pos("t3_end", 320, 120);
        do_move(7, 0, 0, 1'b1, 1'b0, 1'b0);   // 6 -> 13, back-to-back ticks
        do_move(5, 0, 1, 1'b0, 1'b0, 1'b0);   // 13 -> 18
        do_move(3, 0, 2, 1'b1, 1'b1, 1'b0);   // wrap 18 -> 1, request during busy dropped
        check("t4_tile", 32'(mif.tile_idx), 1);
        check_pos("t4_end", 192, 88);
        do_move(0, 0, 0, 1'b0, 1'b0, 1'b1);   // zero-step move
        do_move(1, 1000, 1000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_move(int'($urandom_range(7, 0)), 0, 3, 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // Async reset in the middle of a hop
        mif.move_start = 1'b1;
        mif.move_steps = 3'd3;
        step();
        mif.move_start = 1'b0;
        repeat (4) begin
            mif.frame_tick = 1'b1;
            step();
            mif.frame_tick = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_tile", 32'(mif.tile_idx), 0);
        check_pos("midrst", 160, 88);
        check("midrst_busy", 32'(mif.busy), 0);
        mt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_move(2, 0, 1, 1'b0, 1'b0, 1'b0);   // 0 -> 2 after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
